fetch_unit: RTL and testbench

- Instruction-fetch stage that drives the producer side of the IF/ID pipeline latch.
- Holds the PC and issues read requests to the instruction cache.
- Presents pc/npc/instr/opcode with a valid strobe to the IF/ID latch.
- Buffers a fetched instruction while the pipeline is stalled, redirects on branch/jump flush, and stops fetching after a HALT.

---
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID pipeline latch.
//   CLK/nRST              clock, asynchronous active-low reset
//   ihit/iload            icache read completion and instruction word
//   iREN/iaddr            icache read request and word-aligned address
//   stall                 IF/ID not accepting this cycle
//   flush_branch/branch_target  redirect request and target PC
//   if_valid/if_pc/if_npc/if_instr/if_opcode  instruction presented to IF/ID
//   halted                fetch stopped after delivering a HALT
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h00000000,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        stall,
    input  logic        flush_branch,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_npc,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic        halted
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic        w_fetch;
    logic        w_hold;
    logic        w_active;
    logic        w_is_halt;
    logic        w_buf_halt;
    assign w_fetch    = r_state == FETCH;
    assign w_hold     = r_state == HOLD;
    assign w_active   = w_fetch | w_hold;
    assign w_is_halt  = iload[31:26] == HALT_OP;
    assign w_buf_halt = r_buf_instr[31:26] == HALT_OP;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_pc        <= PC_INIT;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
        end else if (r_state == IDLE) begin
            r_state <= FETCH;
        end else if (flush_branch) begin
            r_pc    <= branch_target & ~32'h3;
            r_state <= FETCH;
        end else if (w_fetch && ihit) begin
            // a HALT leaves pc on its own address so iaddr parks there
            if (!w_is_halt)
                r_pc <= r_pc + 32'd4;
            if (stall) begin
                r_buf_instr <= iload;
                r_buf_pc    <= r_pc;
                r_state     <= HOLD;
            end else if (w_is_halt) begin
                r_state <= HALTED;
            end
        end else if (w_hold && !stall) begin
            r_state <= w_buf_halt ? HALTED : FETCH;
        end
    end
    assign iREN      = w_fetch;
    assign iaddr     = r_pc & ~32'h3;
    assign if_valid  = ((w_fetch & ihit) | w_hold) & ~flush_branch;
    assign if_pc     = w_hold ? r_buf_pc : (w_fetch ? r_pc : '0);
    assign if_instr  = w_hold ? r_buf_instr : (w_fetch ? iload : '0);
    assign if_npc    = w_active ? if_pc + 32'd4 : '0;
    assign if_opcode = if_instr[31:26];
    assign halted    = r_state == HALTED;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    logic        CLK = 0;
    logic        nRST = 0;
    logic        ihit = 0;
    logic [31:0] iload = 0;
    logic        stall = 0;
    logic        flush = 0;
    logic [31:0] bt = 0;
    logic        iren;
    logic [31:0] iaddr;
    logic        valid;
    logic [31:0] ipc;
    logic [31:0] inpc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic        hlt;
    logic        nrst_w = 0;
    logic        iren_w;
    logic [31:0] iaddr_w;
    logic        valid_w;
    logic [31:0] ipc_w;
    logic [31:0] inpc_w;
    logic [31:0] instr_w;
    logic [5:0]  op_w;
    logic        hlt_w;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_pc;
    bit          m_halted;
    logic [31:0] bq_i[$];
    logic [31:0] bq_p[$];

    fetch_unit u_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iren), .iaddr(iaddr),
        .stall(stall), .flush_branch(flush), .branch_target(bt), .if_valid(valid),
        .if_pc(ipc), .if_npc(inpc), .if_instr(instr), .if_opcode(op), .halted(hlt)
    );

    fetch_unit #(.PC_INIT(32'hFFFFFFFC)) u_wrap (
        .CLK(CLK), .nRST(nrst_w), .ihit(1'b1), .iload(32'h20010001), .iREN(iren_w), .iaddr(iaddr_w),
        .stall(1'b0), .flush_branch(1'b0), .branch_target(32'h0), .if_valid(valid_w),
        .if_pc(ipc_w), .if_npc(inpc_w), .if_instr(instr_w), .if_opcode(op_w), .halted(hlt_w)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 0; ihit = 1; stall = 1; flush = 1; bt = $urandom;
        #1;
        chk("rst_iren", iren, 0);
        chk("rst_iaddr", iaddr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pc", ipc, 0);
        chk("rst_npc", inpc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_op", op, 0);
        chk("rst_halted", hlt, 0);
        m_pc = 0; m_halted = 0; bq_i.delete(); bq_p.delete();
        @(negedge CLK);
        nRST = 1;
        #1;
        chk("idle_iren", iren, 0);
        chk("idle_valid", valid, 0);
        chk("idle_iaddr", iaddr, 0);
    endtask

    task automatic step(input logic h, input logic [31:0] ld, input logic s, input logic f, input logic [31:0] t);
        logic        e_iren, e_valid;
        logic [31:0] e_pc, e_instr;
        @(negedge CLK);
        ihit = h; iload = ld; stall = s; flush = f; bt = t;
        #1;
        e_iren = 0; e_valid = 0; e_pc = 0; e_instr = 0;
        if (m_halted) begin
        end else if (bq_i.size() != 0) begin
            e_valid = !f; e_pc = bq_p[0]; e_instr = bq_i[0];
        end else begin
            e_iren = 1; e_valid = h & !f; e_pc = m_pc; e_instr = ld;
        end
        chk("iren", iren, e_iren);
        chk("iaddr", iaddr, m_pc);
        chk("valid", valid, e_valid);
        chk("halted", hlt, m_halted);
        if (e_valid) begin
            chk("if_pc", ipc, e_pc);
            chk("if_npc", inpc, e_pc + 32'd4);
            chk("if_instr", instr, e_instr);
            chk("if_opcode", op, e_instr >> 26);
        end
        if (f) begin
            m_pc = t & ~32'h3; m_halted = 0; bq_i.delete(); bq_p.delete();
        end else if (m_halted) begin
        end else if (bq_i.size() != 0) begin
            if (!s) begin
                if (bq_i[0][31:26] == 6'h3F) m_halted = 1;
                bq_i.delete(); bq_p.delete();
            end
        end else if (h) begin
            if (s) begin
                bq_i.push_back(ld); bq_p.push_back(m_pc);
            end else if (ld[31:26] == 6'h3F) begin
                m_halted = 1;
            end
            if (ld[31:26] != 6'h3F) m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  o;
        do_reset();
        step(1, 32'h20010001, 0, 0, 0);
        step(1, 32'h20020002, 0, 0, 0);
        step(1, 32'h20030003, 0, 0, 0);
        step(1, 32'h8C220000, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        step(1, 32'h12345678, 1, 1, 32'h43);
        step(0, 32'h0, 0, 0, 0);
        step(1, 32'h8C220000, 1, 0, 0);
        step(0, 32'h0, 1, 1, 32'h100);
        step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 1, 32'h20);
        step(1, 32'hFFFFFFFF, 0, 0, 0);
        step(1, 32'h20010001, 0, 0, 0);
        step(1, 32'h20010001, 1, 0, 0);
        step(0, 32'h0, 0, 1, 32'h8);
        step(1, 32'h20010001, 0, 0, 0);
        step(1, 32'hFC000000, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        step(1, 32'h20010001, 0, 0, 0);
        step(1, 32'h8C220000, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                r = $urandom;
                o = ($urandom_range(7) == 0) ? 6'h3F : r[31:26];
                step($urandom_range(9) < 7, {o, r[25:0]}, $urandom_range(9) < 3,
                     $urandom_range(9) == 0, $urandom);
            end
        end
        @(negedge CLK);
        nrst_w = 1;
        #1;
        chk("wrap_idle_iren", iren_w, 0);
        chk("wrap_idle_iaddr", iaddr_w, 32'hFFFFFFFC);
        @(negedge CLK);
        #1;
        chk("wrap_iren", iren_w, 1);
        chk("wrap_iaddr0", iaddr_w, 32'hFFFFFFFC);
        chk("wrap_valid", valid_w, 1);
        chk("wrap_npc0", inpc_w, 0);
        @(negedge CLK);
        #1;
        chk("wrap_iaddr1", iaddr_w, 0);
        chk("wrap_npc1", inpc_w, 4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
